// File: rtl/tx_drv_en_ctrl_mc.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tx_drv_en_ctrl_mc : registered multi-channel TX pad driver-enable control |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tx_drv_en_ctrl_mc #(
  parameter int NCH      = 4,
  parameter int DEAD_CYC = 2,
  parameter int PG_FILT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwrgood,
  input  logic           pwrgoodtx,
  input  logic [NCH-1:0] wk_pu_en,
  input  logic [NCH-1:0] wk_pd_en,
  input  logic           compen_n,
  input  logic           compen_p,
  input  logic           tx_en,
  input  logic           sdr_mode_en,
  input  logic           tx_async_en,
  input  logic           gen1_en,
  input  logic [NCH-1:0] data,
  output logic [NCH-1:0] pu_en_gen1,
  output logic [NCH-1:0] pd_en_gen1,
  output logic [NCH-1:0] pu_en_gen2,
  output logic [NCH-1:0] pd_en_gen2,
  output logic [NCH-1:0] wkpu_en,
  output logic [NCH-1:0] wkpd_en,
  output logic [NCH-1:0] settled
);

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_WKPU  = 3'd1,
    M_WKPD  = 3'd2,
    M_COMPN = 3'd3,
    M_COMPP = 3'd4,
    M_GEN1  = 3'd5,
    M_GEN2  = 3'd6
  } mode_t;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_DEAD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam int PGW       = (PG_FILT < 1) ? 1 : $clog2(PG_FILT + 1);
  localparam int DCW       = (DEAD_CYC < 3) ? 1 : $clog2(DEAD_CYC);
  localparam int DC_LOAD_I = (DEAD_CYC > 0) ? DEAD_CYC - 1 : 0;
  localparam logic [DCW-1:0] DC_LOAD = DC_LOAD_I[DCW-1:0];
  localparam logic [PGW-1:0] PG_FULL = PG_FILT[PGW-1:0];

  logic           pg;
  logic           pg_ok;
  logic [PGW-1:0] pg_cnt;
  mode_t          tx_req;
  logic           comp_sel;

  // Qualified power-good also requires the current sample, so a drop acts on the very next edge.
  assign pg    = pwrgood & pwrgoodtx;
  assign pg_ok = pg && (pg_cnt == PG_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_cnt <= '0;
    end else if (!pg) begin
      pg_cnt <= '0;
    end else if (pg_cnt != PG_FULL) begin
      pg_cnt <= pg_cnt + 1'b1;
    end
  end

  assign comp_sel = compen_n ^ compen_p;

  always_comb begin
    tx_req = M_GEN2;
    if (tx_async_en)               tx_req = M_GEN1;
    else if (!tx_en)               tx_req = M_OFF;
    else if (sdr_mode_en || gen1_en) tx_req = M_GEN1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mode_t          req;
    mode_t          cur_q, cur_d;
    mode_t          tgt_q, tgt_d;
    state_t         st_q, st_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           pu1_d, pd1_d, pu2_d, pd2_d, wu_d, wd_d, set_d;
    logic           pu1_q, pd1_q, pu2_q, pd2_q, wu_q, wd_q, set_q;

    always_comb begin
      req = tx_req;
      if (!pg_ok)                       req = M_OFF;
      else if (wk_pu_en[i] ^ wk_pd_en[i]) req = wk_pu_en[i] ? M_WKPU : M_WKPD;
      else if (comp_sel)                req = compen_n ? M_COMPN : M_COMPP;
    end

    always_comb begin
      st_d  = st_q;
      cur_d = cur_q;
      tgt_d = tgt_q;
      cnt_d = cnt_q;
      if (req == M_OFF) begin
        st_d  = S_OFF;
        cur_d = M_OFF;
        tgt_d = M_OFF;
        cnt_d = '0;
      end else begin
        case (st_q)
          S_DEAD: begin
            // A new request restarts the full dead window.
            if (req != tgt_q) begin
              tgt_d = req;
              cnt_d = DC_LOAD;
            end else if (cnt_q == '0) begin
              st_d  = S_ACTIVE;
              cur_d = tgt_q;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: begin
            if (req != cur_q) begin
              if (DEAD_CYC > 0) begin
                st_d  = S_DEAD;
                tgt_d = req;
                cnt_d = DC_LOAD;
              end else begin
                st_d  = S_ACTIVE;
                cur_d = req;
              end
            end
          end
        endcase
      end

      pu1_d = 1'b0;
      pd1_d = 1'b0;
      pu2_d = 1'b0;
      pd2_d = 1'b0;
      wu_d  = 1'b0;
      wd_d  = 1'b0;
      if (st_d == S_ACTIVE) begin
        case (cur_d)
          M_WKPU:  wu_d = 1'b1;
          M_WKPD:  wd_d = 1'b1;
          M_COMPN: begin pu2_d = 1'b1; pd2_d = 1'b1; end
          M_COMPP: begin pu1_d = 1'b1; pd1_d = 1'b1; end
          M_GEN1:  begin pu1_d = data[i]; pd1_d = ~data[i]; end
          M_GEN2:  begin pu2_d = data[i]; pd2_d = ~data[i]; end
          default: ;
        endcase
      end
      set_d = (st_d == S_ACTIVE) || ((st_d == S_OFF) && (req == M_OFF));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= S_OFF;
        cur_q <= M_OFF;
        tgt_q <= M_OFF;
        cnt_q <= '0;
        pu1_q <= 1'b0;
        pd1_q <= 1'b0;
        pu2_q <= 1'b0;
        pd2_q <= 1'b1;
        wu_q  <= 1'b0;
        wd_q  <= 1'b0;
        set_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cur_q <= cur_d;
        tgt_q <= tgt_d;
        cnt_q <= cnt_d;
        pu1_q <= pu1_d;
        pd1_q <= pd1_d;
        pu2_q <= pu2_d;
        pd2_q <= pd2_d;
        wu_q  <= wu_d;
        wd_q  <= wd_d;
        set_q <= set_d;
      end
    end

    assign pu_en_gen1[i] = pu1_q;
    assign pd_en_gen1[i] = pd1_q;
    assign pu_en_gen2[i] = pu2_q;
    assign pd_en_gen2[i] = pd2_q;
    assign wkpu_en[i]    = wu_q;
    assign wkpd_en[i]    = wd_q;
    assign settled[i]    = set_q;

    a_one_group: assert property (@(posedge clk) disable iff (rst)
      $onehot0({pu1_q | pd1_q, pu2_q | pd2_q, wu_q | wd_q}));
    a_gen1_no_shoot: assert property (@(posedge clk) disable iff (rst)
      (st_q == S_ACTIVE && cur_q == M_GEN1) |-> !(pu1_q && pd1_q));
    a_gen2_no_shoot: assert property (@(posedge clk) disable iff (rst)
      (st_q == S_ACTIVE && cur_q == M_GEN2) |-> !(pu2_q && pd2_q));
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_drv_en_ctrl_mc.sv
`default_nettype none
// Bench for tx_drv_en_ctrl_mc: run-length reference model checked every cycle, plus pinned literal vectors.
module tb_tx_drv_en_ctrl_mc;
  localparam int NCH = 4;
  localparam int DEAD_CYC = 2;
  localparam int PG_FILT = 4;
  localparam int MOFF = 0, MWU = 1, MWD = 2, MCN = 3, MCP = 4, MG1 = 5, MG2 = 6, HOLD = -1;

  logic clk = 1'b0;
  logic rst, pwrgood, pwrgoodtx, compen_n, compen_p, tx_en, sdr_mode_en, tx_async_en, gen1_en;
  logic [NCH-1:0] wk_pu_en, wk_pd_en, data;
  logic [NCH-1:0] pu_en_gen1, pd_en_gen1, pu_en_gen2, pd_en_gen2, wkpu_en, wkpd_en, settled;
  logic [27:0] act;

  tx_drv_en_ctrl_mc #(.NCH(NCH), .DEAD_CYC(DEAD_CYC), .PG_FILT(PG_FILT)) dut (
    .clk(clk), .rst(rst), .pwrgood(pwrgood), .pwrgoodtx(pwrgoodtx),
    .wk_pu_en(wk_pu_en), .wk_pd_en(wk_pd_en), .compen_n(compen_n), .compen_p(compen_p),
    .tx_en(tx_en), .sdr_mode_en(sdr_mode_en), .tx_async_en(tx_async_en), .gen1_en(gen1_en),
    .data(data), .pu_en_gen1(pu_en_gen1), .pd_en_gen1(pd_en_gen1), .pu_en_gen2(pu_en_gen2),
    .pd_en_gen2(pd_en_gen2), .wkpu_en(wkpu_en), .wkpd_en(wkpd_en), .settled(settled)
  );

  always #5 clk = ~clk;
  assign act = {pu_en_gen1, pd_en_gen1, pu_en_gen2, pd_en_gen2, wkpu_en, wkpd_en, settled};

  int n_pass = 0;
  int n_total = 0;
  int pin_id = 0;
  int seen_id = 0;
  string pin_name = "";
  logic [27:0] pin_exp = '0;

  // Reference model: a channel drives mode M once M has been requested for DEAD_CYC+1
  // consecutive samples, keeps driving while the request stays M, and an OFF request is immediate.
  int hi_run = 0;
  int run[NCH];
  int prev_req[NCH];
  int drv[NCH];
  logic [27:0] exp_v = 28'h000F000;

  function automatic int want(int ch);
    if (wk_pu_en[ch] ^ wk_pd_en[ch]) return wk_pu_en[ch] ? MWU : MWD;
    if (compen_n ^ compen_p) return compen_n ? MCN : MCP;
    if (tx_async_en) return MG1;
    if (!tx_en) return MOFF;
    if (sdr_mode_en || gen1_en) return MG1;
    return MG2;
  endfunction

  task automatic model_reset();
    hi_run = 0;
    for (int c = 0; c < NCH; c++) begin
      run[c] = 0;
      prev_req[c] = MOFF;
      drv[c] = MOFF;
    end
    exp_v = 28'h000F000;
  endtask

  task automatic model_step();
    logic ok;
    int r;
    logic [NCH-1:0] p1, d1, p2, d2, wu, wd, st;
    ok = (pwrgood && pwrgoodtx) && (hi_run >= PG_FILT);
    hi_run = (pwrgood && pwrgoodtx) ? ((hi_run < 1000) ? hi_run + 1 : hi_run) : 0;
    p1 = '0; d1 = '0; p2 = '0; d2 = '0; wu = '0; wd = '0; st = '0;
    for (int c = 0; c < NCH; c++) begin
      r = ok ? want(c) : MOFF;
      run[c] = (r == prev_req[c]) ? run[c] + 1 : 1;
      prev_req[c] = r;
      if (r == MOFF) drv[c] = MOFF;
      else if (drv[c] != r) drv[c] = (run[c] > DEAD_CYC) ? r : HOLD;
      case (drv[c])
        MWU: wu[c] = 1'b1;
        MWD: wd[c] = 1'b1;
        MCN: begin p2[c] = 1'b1; d2[c] = 1'b1; end
        MCP: begin p1[c] = 1'b1; d1[c] = 1'b1; end
        MG1: begin p1[c] = data[c]; d1[c] = ~data[c]; end
        MG2: begin p2[c] = data[c]; d2[c] = ~data[c]; end
        default: ;
      endcase
      st[c] = (drv[c] != HOLD);
    end
    exp_v = {p1, d1, p2, d2, wu, wd, st};
  endtask

  task automatic compare(string nm, logic [27:0] got, logic [27:0] want_v);
    n_total++;
    if (got === want_v) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want_v);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      if (rst) model_reset();
      compare("model", act, exp_v);
      if (pin_id != seen_id) begin
        seen_id = pin_id;
        compare(pin_name, act, pin_exp);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(string nm, logic [27:0] v);
    pin_name = nm;
    pin_exp = v;
    pin_id++;
  endtask

  initial begin
    rst = 1'b1; pwrgood = 1'b1; pwrgoodtx = 1'b1; wk_pu_en = '0; wk_pd_en = '0;
    compen_n = 1'b0; compen_p = 1'b0; tx_en = 1'b1; sdr_mode_en = 1'b0; tx_async_en = 1'b0;
    gen1_en = 1'b1; data = 4'b1010;
    #1 pin("reset", 28'h000F000);
    tick(2); rst = 1'b0;
    tick(1); pin("pgfilt_e1", 28'h000000F);
    tick(3); pin("pgfilt_e4", 28'h000000F);
    tick(1); pin("first_dead", 28'h0000000);
    tick(2); pin("gen1_data", 28'hA50000F);
    data = 4'b0101;
    tick(1); pin("gen1_toggle", 28'h5A0000F);
    for (int k = 0; k < 6; k++) begin data = ~data; tick(1); end
    data = 4'b0011;
    tick(1); pin("gen1_0011", 28'h3C0000F);
    gen1_en = 1'b0;
    tick(1); pin("mode_dead1", 28'h0000000);
    tick(1); pin("mode_dead2", 28'h0000000);
    tick(1); pin("gen2_data", 28'h003C00F);
    gen1_en = 1'b1;
    tick(3); pin("back_gen1", 28'h3C0000F);
    gen1_en = 1'b0;
    tick(1);
    gen1_en = 1'b1;
    tick(1); pin("reload_dead_a", 28'h0000000);
    tick(1); pin("reload_dead_b", 28'h0000000);
    tick(1); pin("reload_gen1", 28'h3C0000F);
    data = 4'b1100;
    tick(1);
    wk_pu_en = 4'b0001; wk_pd_en = 4'b0010;
    tick(1); pin("weak_dead", 28'hC00000C);
    tick(2); pin("weak_on", 28'hC00012F);
    wk_pu_en = 4'b0001; wk_pd_en = 4'b0001;
    tick(3); pin("weak_both_tx", 28'hC30000F);
    wk_pu_en = '0; wk_pd_en = '0;
    tick(1); pin("weak_clear_nodead", 28'hC30000F);
    compen_n = 1'b1;
    tick(1); pin("comp_dead", 28'h0000000);
    tick(2); pin("compn", 28'h00FF00F);
    compen_p = 1'b1;
    tick(3); pin("comp_both_ignored", 28'hC30000F);
    compen_n = 1'b0; compen_p = 1'b0;
    gen1_en = 1'b0;
    tick(3); pin("gen2_pre_pg", 28'h00C300F);
    pwrgoodtx = 1'b0;
    tick(1); pin("pg_drop", 28'h000000F);
    pwrgoodtx = 1'b1;
    tick(4); pin("pg_refilter", 28'h000000F);
    tick(1); pin("pg_ok_dead", 28'h0000000);
    tick(2); pin("pg_gen2", 28'h00C300F);
    gen1_en = 1'b1;
    tick(1);
    #1 rst = 1'b1;
    pin("async_rst", 28'h000F000);
    tick(1); rst = 1'b0;
    tick(10);
    compen_p = 1'b1;
    tick(3); pin("compp", 28'hFF0000F);
    compen_p = 1'b0; tx_en = 1'b0;
    tick(1); pin("tx_off", 28'h000000F);
    tx_async_en = 1'b1;
    tick(3); pin("async_gen1", 28'hC30000F);
    tx_async_en = 1'b0; tx_en = 1'b1; gen1_en = 1'b0; sdr_mode_en = 1'b1;
    tick(1); pin("sdr_gen1_nodead", 28'hC30000F);
    tick(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
